// File: rtl/cbus_arbiter_n.sv
// cbus_arbiter_n: N-master CBus arbiter that grants a whole burst and routes responses back to the owner.
// Build option: define CBUS_ARB_RR_EN for round-robin; otherwise fixed priority with index 0 highest.
package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;
endpackage

module cbus_arbiter_n
   import cbus_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  cbus_req_t  [NUM_MASTERS-1:0] ireqs,
   output cbus_resp_t [NUM_MASTERS-1:0] iresps,
   output cbus_req_t                    oreq,
   input  cbus_resp_t                   oresp
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDX_W-1:0] r_sel;
   logic [IDX_W-1:0] w_win;
   logic             w_any;
   logic             w_grant;
   logic             w_done;

`ifdef CBUS_ARB_RR_EN
   logic [IDX_W-1:0] r_rr_ptr;
   int unsigned      w_idx;
`endif

   // Winner selection; the candidate index never reaches NUM_MASTERS, even for non-power-of-two counts.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
`ifdef CBUS_ARB_RR_EN
      w_idx = 0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         w_idx = i + 32'(r_rr_ptr);
         if (w_idx >= NUM_MASTERS)
            w_idx = w_idx - NUM_MASTERS;
         if (!w_any && ireqs[IDX_W'(w_idx)].valid) begin
            w_any = 1'b1;
            w_win = IDX_W'(w_idx);
         end
      end
`else
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         if (!w_any && ireqs[IDX_W'(i)].valid) begin
            w_any = 1'b1;
            w_win = IDX_W'(i);
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_done      = 1'b0;
      oreq        = '0;
      iresps      = '0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = BUSY;
               w_grant     = 1'b1;
            end
         end
         BUSY: begin
            oreq          = ireqs[r_sel];
            iresps[r_sel] = oresp;
            if (oresp.ready && oresp.last) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_sel <= '0;
      else if (w_grant)
         r_sel <= w_win;
   end

`ifdef CBUS_ARB_RR_EN
   // Pointer moves past the finishing master on its last beat, before the next IDLE arbitration.
   always_ff @(posedge clk) begin
      if (reset)
         r_rr_ptr <= '0;
      else if (w_done)
         r_rr_ptr <= (r_sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_sel + 1'b1;
   end
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && r_state == BUSY)
         assert (ireqs[r_sel].valid)
            else $error("cbus_arbiter_n: master %0d dropped valid before its last beat", r_sel);
   end
`endif

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// tb_cbus_arbiter_n: directed scoreboard bench for a four-master cbus_arbiter_n.
// Grant order expectations follow the policy chosen by CBUS_ARB_RR_EN.
`timescale 1ns/1ps
module tb_cbus_arbiter_n;
   import cbus_pkg::*;

   localparam int NM = 4;

   typedef struct {
      int          idx;
      logic [31:0] addr;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   cbus_req_t  [NM-1:0] ireqs;
   cbus_resp_t [NM-1:0] iresps;
   cbus_req_t           oreq;
   cbus_resp_t          oresp;

   cbus_req_t m [NM];
   exp_t      exp_q [$];
   int        n_tests = 0;
   int        n_fail  = 0;

   cbus_arbiter_n #(.NUM_MASTERS(NM)) dut (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs),
      .iresps (iresps),
      .oreq   (oreq),
      .oresp  (oresp)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NM; i++)
         ireqs[i] = m[i];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "tb_cbus_arbiter_n: watchdog expired");
   end

   function automatic logic [31:0] addr_of(input int idx);
      return 32'h8000_0000 + 32'(idx << 6);
   endfunction

   function automatic logic [63:0] beat_data(input int idx, input int b);
      return 64'hDA7A_0000_0000_0000 | 64'(idx << 8) | 64'(b);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_grant(input int idx);
      exp_q.push_back('{idx, addr_of(idx)});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NM; i++) m[i].valid = 1'b0;
      oresp = '0;
      step();
      reset = 1'b0;
   endtask

   // Waits for a grant, pops the expected owner and plays `beats` response beats to it.
   task automatic serve(input int beats, input bit drop, input int raise_beat, input int raise_idx);
      int                  n;
      exp_t                e;
      cbus_resp_t [NM-1:0] others;
      n = 0;
      while (oreq.valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("grant_wait", 64'(n < 20), 64'd1);
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("grant_addr", oreq.addr, e.addr);
      check("grant_sel", 64'(dut.r_sel), 64'(e.idx));
      for (int b = 0; b < beats; b++) begin
         if (b == raise_beat) begin
            m[raise_idx].valid = 1'b1;
            expect_grant(raise_idx);
         end
         oresp.ready = 1'b1;
         oresp.last  = (b == beats - 1);
         oresp.data  = beat_data(e.idx, b);
         #1;
         check("beat_valid", oreq.valid, 1);
         check("beat_addr", oreq.addr, e.addr);
         check("beat_ready", iresps[e.idx].ready, 1);
         check("beat_last", iresps[e.idx].last, 64'(b == beats - 1));
         check("beat_data", iresps[e.idx].data, beat_data(e.idx, b));
         others = iresps;
         others[e.idx] = '0;
         check("others_zero", 64'(|others), 0);
         step();
         oresp = '0;
      end
      if (drop) m[e.idx].valid = 1'b0;
      check("bubble_valid", oreq.valid, 0);
      check("bubble_resp", 64'(|iresps), 0);
   endtask

   initial begin
      exp_t e;
      reset = 1'b1;
      oresp = '0;
      for (int i = 0; i < NM; i++) begin
         m[i]      = '0;
         m[i].addr = addr_of(i);
         m[i].len  = 4'd3;
         m[i].data = 64'(i);
      end

      // Reset and ten idle cycles.
      step();
      step();
      check("rst_oreq", 64'(|oreq), 0);
      check("rst_sel", 64'(dut.r_sel), 0);
`ifdef CBUS_ARB_RR_EN
      check("rst_rr", 64'(dut.r_rr_ptr), 0);
`endif
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         check("idle_valid", oreq.valid, 0);
         check("idle_resp", 64'(|iresps), 0);
      end
      check("idle_sel", 64'(dut.r_sel), 0);

      // Single master 1, four-beat read at 0x8000_0040.
      m[1].valid = 1'b1;
      expect_grant(1);
      #1;
      check("req_same_cycle", oreq.valid, 0);
      step();
      check("grant_t1_valid", oreq.valid, 1);
      check("grant_t1_addr", oreq.addr, 32'h8000_0040);
      serve(4, 1'b1, -1, 0);

`ifdef CBUS_ARB_RR_EN
      // Masters 0 and 2 request continuously: grants alternate starting from pointer 0.
      do_reset();
      m[0].valid = 1'b1;
      m[2].valid = 1'b1;
      expect_grant(0);
      expect_grant(2);
      expect_grant(0);
      expect_grant(2);
      serve(1, 1'b0, -1, 0);
      serve(1, 1'b0, -1, 0);
      serve(1, 1'b1, -1, 0);
      serve(1, 1'b1, -1, 0);
`else
      // Masters 0 and 1 request: 0 keeps winning until it drops valid.
      do_reset();
      m[0].valid = 1'b1;
      m[1].valid = 1'b1;
      expect_grant(0);
      expect_grant(0);
      expect_grant(0);
      expect_grant(1);
      serve(1, 1'b0, -1, 0);
      serve(1, 1'b0, -1, 0);
      serve(1, 1'b1, -1, 0);
      serve(1, 1'b1, -1, 0);
`endif

      // Non-preemption: master 0 arrives on beat 2 of master 3's 8-beat burst.
      m[3].valid = 1'b1;
      expect_grant(3);
      step();
      serve(8, 1'b1, 1, 0);
      serve(2, 1'b1, -1, 0);

      // Reset on beat 3 of an 8-beat burst from master 2.
      m[2].valid = 1'b1;
      expect_grant(2);
      step();
      e = exp_q.pop_front();
      check("rb_addr", oreq.addr, e.addr);
      for (int b = 0; b < 2; b++) begin
         oresp.ready = 1'b1;
         oresp.last  = 1'b0;
         oresp.data  = beat_data(2, b);
         #1;
         check("rb_ready", iresps[2].ready, 1);
         step();
         oresp = '0;
      end
      oresp.ready = 1'b1;
      oresp.data  = beat_data(2, 2);
      reset = 1'b1;
      step();
      reset      = 1'b0;
      m[2].valid = 1'b0;
      oresp      = '0;
      #1;
      check("rb_valid", oreq.valid, 0);
      check("rb_resp", 64'(|iresps), 0);
      check("rb_sel", 64'(dut.r_sel), 0);
`ifdef CBUS_ARB_RR_EN
      check("rb_rr", 64'(dut.r_rr_ptr), 0);
`endif
      step();
      check("rb_stay_idle", oreq.valid, 0);
      m[1].valid = 1'b1;
      expect_grant(1);
      step();
      check("fresh_valid", oreq.valid, 1);
      serve(2, 1'b1, -1, 0);

      check("sb_drained", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cbus_arbiter_n.md
# cbus_arbiter_n

Parametrised N-master arbiter for the cache bus (CBus), successor to the fixed two-master instruction/data arbiter in the top level. It sits between the per-master bus converters (instruction, data, page-table walker, DMA, …) and the single outbound CBus port. It grants one master at a time for a full burst and routes responses back. The arbitration policy is selectable: round-robin or fixed priority.

## Interface
- `NUM_MASTERS`, default 2: number of request channels; legal range 2..8.
- `IDX_W`, default `$clog2(NUM_MASTERS)`: width of the grant index; derived, never overridden.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `ireqs` input, `cbus_req_t [NUM_MASTERS-1:0]`: per-master requests. Index 0 is the highest fixed priority.
- `iresps` output, `cbus_resp_t [NUM_MASTERS-1:0]`: per-master responses.
- `oreq` output, `cbus_req_t`: request to memory or the next arbiter level.
- `oresp` input, `cbus_resp_t`: response from memory (`ready`, `last`, `data`).

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: a master is granted; `sel` register (`IDX_W` bits) holds its index.
- IDLE → BUSY:
  - Taken when any `ireqs[i].valid` is high.
  - Winner is chosen combinationally from the current valids and latched into `sel`.
- BUSY → IDLE: taken on the cycle `oresp.ready && oresp.last` is high.
- While BUSY:
  - `oreq = ireqs[sel]`.
  - `iresps[sel] = oresp`.
  - All other `iresps[j]` are driven to zero.
- While IDLE:
  - `oreq` is all zero; in particular `oreq.valid` = 0.
  - Every `iresps[j]` is zero.
- Grant is non-preemptive. A higher-priority request arriving mid-burst waits until the burst's `last` beat.
- If the granted master deasserts `valid` before `last`, that is a protocol violation. The arbiter stays BUSY and forwards `valid` = 0. An assertion fires under simulation.
- `oresp` fields other than `ready`, `last` and `data` pass through unchanged.
- Round-robin pointer `rr_ptr` (`IDX_W` bits):
  - Search starts at `rr_ptr`, wrapping modulo `NUM_MASTERS`.
  - On each BUSY → IDLE transition, `rr_ptr` ← `sel + 1`, wrapping to 0 after `NUM_MASTERS-1`.
- Non-power-of-two `NUM_MASTERS`: indices at or above `NUM_MASTERS` are never selected, and the wrap uses an explicit compare.

## Timing
- Reset values:
  - state = IDLE, `sel` = 0, `rr_ptr` = 0.
  - `oreq` all zero; every `iresps[j]` all zero.
- Arbitration latency:
  - A request seen in IDLE at cycle t appears on `oreq` at t+1.
  - Grant is registered, so there is one bubble cycle per transaction.
- Back-to-back:
  - `last` at cycle t returns the FSM to IDLE at t+1.
  - The next grant becomes visible at t+2.
  - No master is granted twice in a row while another master is pending, in RR mode.
- Simultaneous final beat and new request: the finishing master's `rr_ptr` update is applied before the next arbitration.
- Reset asserted mid-burst: next cycle is IDLE with `oreq.valid` = 0. The in-flight transaction is abandoned and the downstream slave is reset by the same `reset`.
- No combinational path from `oresp` to `oreq`.
- `iresps` depends combinationally on `oresp` and the registered `sel` only.

## Configuration
- `CBUS_ARB_RR_EN` defined: round-robin policy as above.
- `CBUS_ARB_RR_EN` undefined:
  - Fixed priority, lowest index wins.
  - `rr_ptr` is not instantiated.
  - With `NUM_MASTERS` = 2 this is cycle-identical to the legacy two-master arbiter.

## Test plan
- Reset, no requests:
  - `oreq.valid` = 0 and all `iresps.ready` = 0 for 10 cycles.
  - `sel` = 0.
- Single master 1 (`NUM_MASTERS` = 4), read of `len` 4 beats at addr 0x8000_0040:
  - `oreq.addr` = 0x8000_0040 one cycle after `valid`.
  - `iresps[1]` receives 4 ready beats, `last` on the 4th.
  - `iresps[0,2,3]` stay zero.
- RR fairness, masters 0 and 2 requesting continuously with 1-beat transactions:
  - Grants alternate 0, 2, 0, 2.
  - Each grant is followed by one IDLE cycle.
- Fixed priority (macro off), masters 0 and 1 both valid:
  - Master 0 is granted for 3 consecutive transactions.
  - Master 1 is granted only after master 0 drops `valid`.
- Non-preemption: master 3 is mid-burst (beat 2 of 8) when master 0 raises `valid`. Master 0 is granted only after master 3's `last`.
- Reset on beat 3 of 8: next cycle `oreq.valid` = 0, state IDLE and `rr_ptr` = 0. A fresh request is then granted normally.
